// File: rtl/instr_fetch_queue.sv
// Instruction fetch with a small prefetch FIFO and branch redirect/flush.
// Optional FETCH_PERF_EN adds fetch/stall performance counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] out_pc,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [24:0] imm
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic          issue, push, pop, room;
    logic [63:0]   head;

    // The outstanding request reserves a slot so its push can never overflow.
    assign room  = ({1'b0, count_q} + {{CW{1'b0}}, (state_q == S_WAIT)}) < (CW+1)'(DEPTH);
    assign issue = (state_q == S_IDLE) && !redirect && room;
    assign push  = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop   = out_valid && out_ready && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_pc & ~32'h3;
            // A response arriving in the redirect cycle settles the pending request.
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid)
                state_d = S_DRAIN;
            else
                state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (issue) state_d = S_WAIT;
                S_WAIT:  if (imem_rvalid) begin
                             state_d    = S_IDLE;
                             fetch_pc_d = fetch_pc_q + 32'd4;
                         end
                S_DRAIN: if (imem_rvalid) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (push) begin
                mem_d[wr_ptr_q] = {fetch_pc_q, imem_rdata};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) mem_q <= mem_d;

    assign imem_req  = issue && !Reset;
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0) && !Reset;
    assign head      = mem_q[rd_ptr_q];
    assign out_pc    = out_valid ? head[63:32] : 32'h0;
    assign instr     = out_valid ? head[31:0]  : 32'h0;
    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign rd        = instr[11:7];
    assign imm       = instr[31:7];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [32:0] flush_sum;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        flush_sum      = {1'b0, perf_flushed_q} + 33'(count_q);
        perf_flushed_d = perf_flushed_q;
        if (push && perf_fetched_q != 32'hFFFF_FFFF)
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (out_ready && !out_valid && perf_stall_q != 32'hFFFF_FFFF)
            perf_stall_d = perf_stall_q + 32'd1;
        if (redirect)
            perf_flushed_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: latency-programmable memory model plus
// a manual response path for the reset-mid-request scenario.
module tb_instr_fetch_queue;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, instr;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [24:0] imm;

    int checks = 0;
    int errors = 0;

    logic        mem_en = 1'b1;
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] maddr = '0;
    logic        model_rvalid = 1'b0;
    logic [31:0] model_rdata = '0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;

    assign imem_rvalid = mem_en ? model_rvalid : man_rvalid;
    assign imem_rdata  = mem_en ? model_rdata  : man_rdata;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .Reset(Reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .instr(instr), .op(op), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[24:0], 7'h13};
    endfunction

    // Memory answers exactly `lat` cycles after the request cycle.
    always @(negedge CLK) begin
        model_rvalid = 1'b0;
        if (!mem_en) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    model_rvalid = 1'b1;
                    model_rdata  = word_of(maddr);
                end
            end
            if (imem_req) begin
                cnt   = lat;
                maddr = imem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_seq();
        Reset = 1'b1; redirect = 1'b0; out_ready = 1'b0;
        repeat (4) tick();
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] addrs [8];
        int   nreq;
        int   n;
        logic found;

        Reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; lat = 1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);

        // First fetch: addi x1,x0,5 at 0x0
        Reset = 1'b0; #1;
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        tick();
        chk("t1_wait_noreq", 32'(imem_req), 32'h0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_op", 32'(op), 32'h13);
        chk("t1_rd", 32'(rd), 32'h1);
        chk("t1_rs1", 32'(rs1), 32'h0);
        chk("t1_funct3", 32'(funct3), 32'h0);
        chk("t1_imm", 32'(imm), 32'h000A001);
        chk("t1_out_pc", out_pc, 32'h0);

        // Fill with no consumer: exactly DEPTH requests
        reset_seq();
        nreq = 0;
        for (int i = 0; i < 14; i++) begin
            if (imem_req) begin
                if (nreq < 8) addrs[nreq] = imem_addr;
                nreq++;
            end
            tick();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_addr", addrs[i], 32'(i * 4));
        chk("t2_req_idle", 32'(imem_req), 32'h0);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_out_pc", out_pc, 32'h0);

        // One pop frees a slot
        out_ready = 1'b1; #1;
        chk("t3_head", out_pc, 32'h0);
        tick();
        out_ready = 1'b0; #1;
        chk("t3_req", 32'(imem_req), 32'h1);
        chk("t3_addr", imem_addr, 32'h10);
        chk("t3_out_pc", out_pc, 32'h4);

        // Redirect during WAIT with latency 3
        lat = 3;
        reset_seq();
        chk("t4_req0", 32'(imem_req), 32'h1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h103; #1;
        chk("t4_redir_noreq", 32'(imem_req), 32'h0);
        tick();
        redirect = 1'b0; #1;
        chk("t4_flushed", 32'(out_valid), 32'h0);
        chk("t4_drain_noreq_a", 32'(imem_req), 32'h0);
        tick();
        chk("t4_drain_noreq_b", 32'(imem_req), 32'h0);
        tick();
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h100);
        n = 0;
        while (!out_valid && n < 12) begin tick(); n++; end
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_out_pc", out_pc, 32'h100);
        chk("t4_instr", instr, 32'h0000_8013);

        // Redirect + pop together with two entries queued
        lat = 1;
        reset_seq();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
            else tick();
        end
        chk("t5_found", 32'(found), 32'h1);
        redirect = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1; #1;
        chk("t5_redir_noreq", 32'(imem_req), 32'h0);
        chk("t5_head_pc", out_pc, 32'h0);
        tick();
        redirect = 1'b0; out_ready = 1'b0; #1;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_out_pc", out_pc, 32'h0);
        chk("t5_instr", instr, 32'h0);
        chk("t5_req", 32'(imem_req), 32'h1);
        chk("t5_addr", imem_addr, 32'h200);
        n = 0;
        while (!out_valid && n < 12) begin tick(); n++; end
        chk("t5_refill_pc", out_pc, 32'h200);

        // Reset while waiting; stale response lands in IDLE
        mem_en = 1'b0;
        reset_seq();
        chk("t6_req0", 32'(imem_req), 32'h1);
        chk("t6_addr0", imem_addr, 32'h0);
        tick();
        Reset = 1'b1; #1;
        chk("t6_rst_noreq", 32'(imem_req), 32'h0);
        tick();
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_pc", out_pc, 32'h0);
        tick();
        Reset = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1111_1113; #1;
        chk("t6_req", 32'(imem_req), 32'h1);
        chk("t6_addr", imem_addr, 32'h0);
        tick();
        man_rvalid = 1'b0; #1;
        chk("t6_no_push", 32'(out_valid), 32'h0);
        chk("t6_wait_noreq", 32'(imem_req), 32'h0);
        man_rvalid = 1'b1; man_rdata = 32'h2222_2213;
        tick();
        man_rvalid = 1'b0; #1;
        chk("t6_valid", 32'(out_valid), 32'h1);
        chk("t6_out_pc", out_pc, 32'h0);
        chk("t6_instr", instr, 32'h2222_2213);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
